// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a contiguous, wrapping range of the register file
// through its combinational read port and streams each value out over a
// valid/ready byte interface.
// Optional feature: define REG_DUMP_CHECKSUM_EN to append an XOR checksum
// byte after the data bytes. That checksum byte carries out_last.
module reg_dump_reader #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] start_addr,
  input  logic [D:0]   len,
  output logic [D-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam logic [D:0] DEPTH = {1'b1, {D{1'b0}}};
  localparam logic [D:0] ONE   = (D+1)'(1);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

  state_t       state;
  state_t       state_next;
  logic [D-1:0] ptr;
  logic [D:0]   rem;
  logic [D-1:0] rd_addr_q;
  logic [D:0]   len_clamped;
  logic         accept;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [W-1:0] csum;
`endif

  // A length above the register file depth dumps the whole file exactly once.
  assign len_clamped = (len > DEPTH) ? DEPTH : len;
  assign accept      = out_valid && out_ready;

  // The read port sees the live pointer during FETCH.
  // Outside FETCH it keeps the last address that was fetched.
  assign rd_addr = (state == FETCH) ? ptr : rd_addr_q;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // State register. Reset overrides everything, including a dump in progress.
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. A start is only honoured in IDLE; a start that arrives
  // while busy is dropped and is not queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (len == '0) ? DONE : FETCH;
      FETCH: state_next = SEND;
      SEND: begin
        if (accept) begin
          if (rem == ONE) begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else begin
            state_next = FETCH;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM:  if (accept) state_next = DONE;
`endif
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: pointer and remaining count, the registered output byte, and
  // (when enabled) the running checksum.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ptr       <= '0;
      rem       <= '0;
      rd_addr_q <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr <= start_addr;
            rem <= len_clamped;
`ifdef REG_DUMP_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        FETCH: begin
          rd_addr_q <= ptr;
          out_data  <= rd_data;
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= (rem == ONE);
`endif
        end
        SEND: begin
          if (accept) begin
            rem       <= rem - ONE;
            ptr       <= ptr + 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= csum ^ out_data;
            if (rem == ONE) begin
              out_data  <= csum ^ out_data;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
            end
`endif
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Testbench for reg_dump_reader.
// A behavioural model turns (start_addr, len, register contents) into the
// expected byte sequence. Each test task compares that sequence with the
// bytes the DUT actually hands over.
module tb_reg_dump_reader;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] regs [16];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] obs_q [$];
  logic       last_q [$];
  logic [7:0] exp_q [$];
  int first_valid;
  int done_cnt;
  int done_cyc;
  int unstable;
  bit timed_out;

  reg_dump_reader #(.W(8), .D(4)) dut (
    .CLK(CLK), .reset(reset), .start(start), .start_addr(start_addr),
    .len(len), .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  assign rd_data = regs[rd_addr];

  // Reference model: the registers start_addr, start_addr+1, ... (wrapping
  // modulo 16), min(len,16) of them. With the checksum feature, their XOR
  // follows as one extra byte. Only the final entry carries out_last.
  function automatic void build_expected(input logic [3:0] sa, input logic [4:0] ln);
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = (int'(ln) > 16) ? 16 : int'(ln);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(regs[(int'(sa) + i) % 16]);
      x = x ^ regs[(int'(sa) + i) % 16];
    end
`ifdef REG_DUMP_CHECKSUM_EN
    if (n > 0) exp_q.push_back(x);
`endif
  endfunction

  // Drives one dump and records what the DUT produced; it makes no judgement.
  // Inputs are driven and outputs sampled on the falling edge.
  task automatic run_dump(input logic [3:0] sa, input logic [4:0] ln, input int stall_pct,
                          input int stall_byte, input int stall_len, input int restart_cyc);
    int stalls;
    logic rdy;
    logic prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    obs_q.delete();
    last_q.delete();
    first_valid = -1;
    done_cnt = 0;
    done_cyc = -1;
    unstable = 0;
    timed_out = 1;
    stalls = 0;
    prev_stall = 0;
    prev_data = 8'h00;
    prev_last = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    start_addr = sa;
    len = ln;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge CLK);
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        start_addr = sa + 4'd7;
        len = 5'd2;
      end
      rdy = ($urandom_range(0, 99) >= stall_pct);
      if (out_valid === 1'b1 && obs_q.size() == stall_byte && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end
      out_ready = rdy;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        unstable++;
      prev_stall = (out_valid === 1'b1) && !rdy;
      prev_data = out_data;
      prev_last = out_last;
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (out_valid === 1'b1 && rdy) begin
        obs_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        timed_out = 0;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start_addr = 4'd0;
    len = 5'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_last got %b expected 0", out_last); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_out_data got %h expected 00", out_data); end
    n_cmp++; if (rd_addr !== 4'd0) begin n_err++; $display("[TB] FAIL reset_rd_addr got %h expected 0", rd_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) regs[i] = 8'h10 + 8'(i);
    build_expected(4'd2, 5'd3);
    run_dump(4'd2, 5'd3, 0, -1, 0, -1);
    n_cmp++; if (timed_out) begin n_err++; $display("[TB] FAIL basic_timeout got 1 expected 0"); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL basic_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL basic_byte%0d got %h expected %h", i, obs_q[i], exp_q[i]); end
      n_cmp++; if (last_q[i] !== (i == exp_q.size() - 1)) begin n_err++; $display("[TB] FAIL basic_last%0d got %b expected %b", i, last_q[i], i == exp_q.size() - 1); end
    end
`ifndef REG_DUMP_CHECKSUM_EN
    n_cmp++; if (obs_q.size() > 2 && obs_q[2] !== 8'h14) begin n_err++; $display("[TB] FAIL basic_const got %h expected 14", obs_q[2]); end
`endif
    n_cmp++; if (first_valid != 2) begin n_err++; $display("[TB] FAIL basic_latency got %0d expected 2", first_valid); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("[TB] FAIL basic_done_cnt got %0d expected 1", done_cnt); end
    @(negedge CLK);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL basic_done_pulse got %b expected 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL basic_busy_after got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    build_expected(4'd14, 5'd4);
    run_dump(4'd14, 5'd4, 20, -1, 0, -1);
    n_cmp++; if (timed_out) begin n_err++; $display("[TB] FAIL wrap_timeout got 1 expected 0"); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL wrap_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL wrap_byte%0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (obs_q.size() > 2 && obs_q[2] !== 8'h10) begin n_err++; $display("[TB] FAIL wrap_const got %h expected 10", obs_q[2]); end
    @(negedge CLK);
  endtask

  task automatic test_empty_and_clamp();
    run_dump(4'd5, 5'd0, 0, -1, 0, -1);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("[TB] FAIL empty_count got %0d expected 0", obs_q.size()); end
    n_cmp++; if (first_valid != -1) begin n_err++; $display("[TB] FAIL empty_valid got %0d expected -1", first_valid); end
    n_cmp++; if (done_cyc != 1) begin n_err++; $display("[TB] FAIL empty_done_cyc got %0d expected 1", done_cyc); end
    @(negedge CLK);
    build_expected(4'd5, 5'd20);
    run_dump(4'd5, 5'd20, 10, -1, 0, -1);
    n_cmp++; if (exp_q.size() < 16) begin n_err++; $display("[TB] FAIL clamp_model got %0d expected 16", exp_q.size()); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL clamp_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL clamp_byte%0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    build_expected(4'd3, 5'd4);
    run_dump(4'd3, 5'd4, 0, 1, 5, 3);
    n_cmp++; if (timed_out) begin n_err++; $display("[TB] FAIL bp_timeout got 1 expected 0"); end
    n_cmp++; if (unstable != 0) begin n_err++; $display("[TB] FAIL bp_stable got %0d changes expected 0", unstable); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL bp_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL bp_byte%0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (done_cyc < 8) begin n_err++; $display("[TB] FAIL bp_done_cyc got %0d expected at least 8", done_cyc); end
    repeat (3) begin
      @(negedge CLK);
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL bp_no_queue got valid=%b busy=%b expected 0 0", out_valid, busy); end
    end
  endtask

  task automatic test_reset_mid_dump();
    @(negedge CLK);
    start = 1'b1; start_addr = 4'd0; len = 5'd10; out_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL mid_precond got %b expected 1", out_valid); end
    reset = 1'b1;
    @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_out_valid got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL mid_busy got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL mid_done got %b expected 0", done); end
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_no_partial got %b expected 0", out_valid); end
    build_expected(4'd9, 5'd3);
    run_dump(4'd9, 5'd3, 0, -1, 0, -1);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL mid_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL mid_byte%0d got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic [3:0] sa;
    logic [4:0] ln;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
      sa = 4'($urandom_range(0, 15));
      ln = 5'($urandom_range(0, 20));
      build_expected(sa, ln);
      run_dump(sa, ln, 35, -1, 0, -1);
      n_cmp++; if (timed_out) begin n_err++; $display("[TB] FAIL rnd%0d_timeout got 1 expected 0", t); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL rnd%0d_count got %0d expected %0d", t, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++; if (obs_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
          n_err++; $display("[TB] FAIL rnd%0d_byte%0d got %h/%b expected %h/%b", t, i, obs_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
        end
      end
      n_cmp++; if (first_valid != ((ln == 0) ? -1 : 2)) begin n_err++; $display("[TB] FAIL rnd%0d_latency got %0d", t, first_valid); end
      @(negedge CLK);
    end
  endtask

`ifdef REG_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    regs[0] = 8'hA5; regs[1] = 8'h0F; regs[2] = 8'h3C;
    run_dump(4'd0, 5'd3, 0, -1, 0, -1);
    n_cmp++; if (obs_q.size() != 4) begin n_err++; $display("[TB] FAIL csum_count got %0d expected 4", obs_q.size()); end
    n_cmp++; if (obs_q.size() == 4 && obs_q[3] !== 8'h96) begin n_err++; $display("[TB] FAIL csum_value got %h expected 96", obs_q[3]); end
    n_cmp++; if (obs_q.size() == 4 && (last_q[0] | last_q[1] | last_q[2] | !last_q[3]) !== 1'b0) begin
      n_err++; $display("[TB] FAIL csum_last got %b%b%b%b expected 0001", last_q[0], last_q[1], last_q[2], last_q[3]);
    end
    @(negedge CLK);
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    test_reset();
    test_basic();
    test_wrap();
    test_empty_and_clamp();
    test_backpressure();
    test_reset_mid_dump();
    test_random();
`ifdef REG_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug/readout engine that walks a contiguous range of the CPU register file through a read port and streams each register value out over a valid/ready byte interface.
- Sits beside the register file, on the opposite side of its write path: the register file is written by the datapath, and this block reads it for testbench scoreboarding and host-side state dumps.
- Drives the register file read address itself and samples the combinational read data.

Parameters:
- W, 8, data path width (register width, stream byte width).
- D, 4, register pointer width; register file depth is 2**D.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- start_addr  input  D  first register index of the dump.
- len  input  D+1  number of registers to read; 0 = empty dump; values above 2**D clamp to 2**D.
- rd_addr  output  D  read address driven to the register file read port.
- rd_data  input  W  combinational register file read data for rd_addr.
- out_data  output  W  stream byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle when out_valid is also high.
- out_last  output  1  high with the final byte of the dump.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at dump completion.

Behaviour:
- Reset (synchronous, active-high; takes priority over all else, including mid-dump):
  - state=IDLE; rd_addr=0; out_data=0; out_valid=0; out_last=0; busy=0; done=0.
  - Remaining count and address pointer cleared.
  - No partial byte is emitted after reset.
- States: IDLE, FETCH, SEND, CSUM (CSUM exists only with the optional feature), DONE.
- IDLE:
  - start=1 with len≠0: latch ptr=start_addr, rem=min(len, 2**D), go to FETCH.
  - start=1 with len=0: go to DONE directly; no bytes emitted.
  - start while busy is ignored (there is no queueing).
- FETCH (1 cycle):
  - rd_addr=ptr.
  - At the clock edge: out_data<=rd_data, out_valid<=1, out_last<=(rem==1 and the checksum feature is disabled), go to SEND.
- SEND:
  - out_valid held at 1; out_data and out_last stable until accepted.
  - Acceptance is out_valid && out_ready. On acceptance:
    - rem<=rem-1; ptr<=(ptr+1) mod 2**D (wraps 15→0 at D=4).
    - If rem==1: go to CSUM if the checksum feature is enabled, else DONE.
    - Otherwise go to FETCH.
  - out_valid drops in FETCH. Throughput is therefore 1 byte per 2 cycles at best.
  - out_ready held low stalls indefinitely with no data change.
- DONE (1 cycle): done=1, out_valid=0, out_last=0; go to IDLE.
- Latency: start at cycle t → first out_valid at t+2. A len=0 start → done at t+1.
- rd_addr holds its last value outside FETCH.
- The register file may change during a dump. Each byte reflects register contents at its own FETCH cycle; there is no snapshot.
- Arithmetic: ptr is D bits and wraps naturally. rem is D+1 bits and never underflows.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - Running W-bit XOR of every data byte accepted in SEND, cleared on start.
  - After the last data byte is accepted: CSUM state, out_data=XOR, out_valid=1, out_last=1. Held until out_ready, then DONE.
  - Data bytes never assert out_last.
  - An empty dump (len=0) emits no checksum.
- Not defined:
  - No CSUM state, no XOR register.
  - out_last rides on the final data byte.

Test Plan:
1. Reset, preload r0..r15 = 0x10..0x1F; start_addr=2, len=3, out_ready=1 → out_data 0x12, 0x13, 0x14; out_last only on 0x14; first out_valid 2 cycles after start; done pulse once; busy low afterward.
2. start_addr=14, len=4 → bytes 0x1E, 0x1F, 0x10, 0x11 (wrap at 16).
3. len=0 → no out_valid; done pulses 1 cycle after start. len=20 → exactly 16 bytes, clamped.
4. Backpressure: out_ready low for 5 cycles during the second byte → out_data/out_valid/out_last stable for all 5 cycles; no byte lost or duplicated. Second start during busy → ignored.
5. Reset asserted while in SEND, mid-dump → next cycle out_valid=0, busy=0, done=0; a fresh start then dumps correctly from its own start_addr.
6. (REG_DUMP_CHECKSUM_EN) start_addr=0, len=3 with r0=0xA5, r1=0x0F, r2=0x3C → bytes 0xA5, 0x0F, 0x3C, then 0x96 with out_last=1.
